mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
//
// PURPOSE
// Bus interface between the 6502 core and an external asynchronous SRAM/ROM.
// Takes one-cycle read/write requests, drives chip-enable, output-enable and
// write-enable strobes with PARAMETER-set wait states, and returns a
// registered read byte plus a one-cycle rdy pulse. All fetch, vector and
// operand traffic from the core passes through this block.
//
// PARAMETERS
// ADDR_W       16  address width in bits
// DATA_W        8  data width in bits
// WAIT_STATES   1  extra ACCESS cycles beyond the first; legal range 0..15
//
// PORTS
// clk          in   1       system clock, rising edge
// resetn       in   1       asynchronous active-low reset
// req          in   1       one-cycle request strobe from core
// we           in   1       1 = write, 0 = read; sampled with req
// addr         in   ADDR_W  request address; sampled with req
// wr_data      in   DATA_W  write byte; sampled with req
// rd_data      out  DATA_W  last completed read byte, registered
// rdy          out  1       one-cycle pulse: access complete
// busy         out  1       1 whenever state != IDLE
// ovr          out  1       sticky: a req arrived while busy (cleared by reset only)
// mem_addr     out  ADDR_W  external address, registered
// mem_dout     out  DATA_W  external write data, registered
// mem_din      in   DATA_W  external read data
// mem_ce_n     out  1       chip enable, active low
// mem_oe_n     out  1       output enable, active low
// mem_we_n     out  1       write enable, active low
//
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; rd_data, mem_addr, mem_dout = 0;
//   rdy, busy, ovr = 0; mem_ce_n, mem_oe_n, mem_we_n = 1. Reset mid-access aborts
//   it immediately: strobes high, no rdy pulse.
// - One-hot FSM: IDLE -> ACCESS -> DONE -> IDLE.
// - IDLE: on req=1 capture addr/we/wr_data into mem_addr/mem_dout/op reg,
//   load wait counter with WAIT_STATES, go ACCESS.
// - ACCESS: mem_ce_n=0; read: mem_oe_n=0; write: mem_we_n=0. Lasts WAIT_STATES+1
//   cycles (counter decrements to 0). On the last ACCESS cycle a read latches
//   mem_din into rd_data. Go DONE.
// - DONE: mem_ce_n=0, mem_oe_n=mem_we_n=1 (write-data/address hold), rdy=1 for
//   this cycle only. Go IDLE.
// - Latency: req at cycle n -> rdy at cycle n+WAIT_STATES+2; rd_data valid same
//   cycle as rdy and held until the next read completes. Writes never alter rd_data.
// - req while busy (ACCESS or DONE): dropped, not queued; ovr <= 1. In-flight
//   access completes with its original captured address/data.
// - mem_addr/mem_dout stable from first ACCESS cycle through DONE; they retain
//   values in IDLE.
// - Minimum request spacing: WAIT_STATES+3 cycles (next req accepted in IDLE).
// - All outputs registered; no combinational path from inputs to outputs.
// - Counter width max(1, $clog2(WAIT_STATES+1)); no wrap: reloads only in IDLE.
//
// STRUCTURE
// - Shared package bus_pkg: one-hot state indices (IDLE, ACCESS, DONE),
//   DATA_W/ADDR_W defaults, MAX_WAIT_STATES = 15.
// - One sub-module natural: wait_counter (load/decrement/zero flag).
// - Elaboration-time check: WAIT_STATES > 15 is a fatal error.
//
// TESTING
// 1 Reset: hold resetn=0 -> mem_ce_n=mem_oe_n=mem_we_n=1, rdy=0, busy=0, rd_data=8'h00.
// 2 Read, WAIT_STATES=1: req, addr=16'hFFFC, mem_din=8'h34 -> oe_n low 2 cycles,
//   rdy at n+3, rd_data=8'h34, busy low at n+4.
// 3 Write: addr=16'h0200, wr_data=8'hA9 -> we_n low 2 cycles, mem_dout=8'hA9 and
//   mem_addr=16'h0200 stable through DONE, rd_data unchanged.
// 4 Overrun: second req (addr=16'h1234) during ACCESS -> ovr=1, first access completes
//   at original address, only one rdy pulse.
// 5 Abort: resetn low during ACCESS -> strobes high same cycle, no rdy, state IDLE.
// 6 WAIT_STATES=0 back-to-back reads 16'hFFFC/16'hFFFD (8'h00/8'h80) -> rdy at n+2 and
//   n+5, rd_data 8'h00 then 8'h80, ovr stays 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the 6502 memory bus controller.
//   - default address/data widths
//   - upper bound on configurable wait states
//   - one-hot state encoding for the access FSM
//   - helper to size the wait-state counter
package bus_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 8;
  localparam int MAX_WAIT_STATES = 15;

  // One-hot bit positions
  localparam int S_IDLE   = 0;
  localparam int S_ACCESS = 1;
  localparam int S_DONE   = 2;
  localparam int N_STATES = 3;

  typedef enum logic [N_STATES-1:0] {
    IDLE   = 3'b001,
    ACCESS = 3'b010,
    DONE   = 3'b100
  } state_e;

  // Counter must hold WAIT_STATES; never narrower than one bit.
  function automatic int cnt_width(input int wait_states);
    int w;
    w = $clog2(wait_states + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Wait-state down counter for the bus access phase.
// Ports:
//   clk     in   system clock
//   resetn  in   asynchronous active-low reset
//   load    in   load LOAD_VAL (start of an access)
//   dec     in   decrement by one
//   zero    out  counter currently holds zero
// Loads only when asked; decrement is gated by the caller so it never wraps.
module wait_counter #(
  parameter int WIDTH    = 1,
  parameter int LOAD_VAL = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= WIDTH'(LOAD_VAL);
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Bus interface between the 6502 core and an external asynchronous SRAM/ROM.
// A one-cycle request is turned into a strobed access of WAIT_STATES+1 cycles
// followed by a one-cycle DONE phase that pulses rdy.
// Ports:
//   clk, resetn            clock / async active-low reset
//   req, we, addr, wr_data request from the core (sampled together)
//   rd_data                last completed read byte (registered)
//   rdy                    one-cycle completion pulse
//   busy                   high whenever the FSM is not IDLE
//   ovr                    sticky flag: a request was dropped while busy
//   mem_addr, mem_dout     registered external address / write data
//   mem_din                external read data
//   mem_ce_n/oe_n/we_n     registered active-low memory strobes
module mem_bus_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy,
  output logic              busy,
  output logic              ovr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n
);

  localparam int CNT_W = cnt_width(WAIT_STATES);

  if (WAIT_STATES > MAX_WAIT_STATES || WAIT_STATES < 0) begin : g_ws_check
    $fatal(1, "mem_bus_ctrl: WAIT_STATES must be within 0..15");
  end

  state_e state_q, state_d;
  logic   op_we_q;
  logic   cnt_zero;
  logic   accept;
  logic   we_next;

  // Output values for the next cycle, registered below
  logic   ce_n_d, oe_n_d, we_n_d, rdy_d, busy_d;

  assign accept  = (state_q == IDLE) && req;
  // Direction of the access the FSM is about to be in
  assign we_next = accept ? we : op_we_q;

  wait_counter #(
    .WIDTH    (CNT_W),
    .LOAD_VAL (WAIT_STATES)
  ) u_wait (
    .clk    (clk),
    .resetn (resetn),
    .load   (accept),
    .dec    (state_q == ACCESS),
    .zero   (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req)      state_d = ACCESS;
      ACCESS:  if (cnt_zero) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the strobes can be registered
  // and still line up with the state they belong to.
  always_comb begin
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    rdy_d  = 1'b0;
    busy_d = 1'b0;
    unique case (state_d)
      ACCESS: begin
        ce_n_d = 1'b0;
        oe_n_d = we_next;
        we_n_d = !we_next;
        busy_d = 1'b1;
      end
      DONE: begin
        ce_n_d = 1'b0;
        rdy_d  = 1'b1;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ce_n <= 1'b1;
      mem_oe_n <= 1'b1;
      mem_we_n <= 1'b1;
      rdy      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      mem_ce_n <= ce_n_d;
      mem_oe_n <= oe_n_d;
      mem_we_n <= we_n_d;
      rdy      <= rdy_d;
      busy     <= busy_d;
    end
  end

  // Request capture: address/data hold through DONE and retain in IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr <= '0;
      mem_dout <= '0;
      op_we_q  <= 1'b0;
    end else if (accept) begin
      mem_addr <= addr;
      mem_dout <= wr_data;
      op_we_q  <= we;
    end
  end

  // Read data is sampled on the final ACCESS cycle, visible with rdy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data <= '0;
    end else if ((state_q == ACCESS) && cnt_zero && !op_we_q) begin
      rd_data <= mem_din;
    end
  end

  // Requests arriving while busy are dropped; remember that it happened
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovr <= 1'b0;
    end else if (req && (state_q != IDLE)) begin
      ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  int          vec = 0;
  int          miss = 0;

  // DUT A: WAIT_STATES = 1
  logic        req_a = 1'b0, we_a = 1'b0;
  logic [15:0] addr_a = '0;
  logic [7:0]  wr_a = '0, din_a = '0;
  logic [7:0]  rd_a;
  logic        rdy_a, busy_a, ovr_a, ce_a, oe_a, wen_a;
  logic [15:0] maddr_a;
  logic [7:0]  mdout_a;

  // DUT B: WAIT_STATES = 0
  logic        req_b = 1'b0, we_b = 1'b0;
  logic [15:0] addr_b = '0;
  logic [7:0]  wr_b = '0, din_b;
  logic [7:0]  rd_b;
  logic        rdy_b, busy_b, ovr_b, ce_b, oe_b, wen_b;
  logic [15:0] maddr_b;
  logic [7:0]  mdout_b;

  // Tiny vector ROM behind DUT B
  assign din_b = (maddr_b == 16'hFFFD) ? 8'h80 : 8'h00;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(1)) dut_a (
    .clk(clk), .resetn(resetn), .req(req_a), .we(we_a), .addr(addr_a),
    .wr_data(wr_a), .rd_data(rd_a), .rdy(rdy_a), .busy(busy_a), .ovr(ovr_a),
    .mem_addr(maddr_a), .mem_dout(mdout_a), .mem_din(din_a),
    .mem_ce_n(ce_a), .mem_oe_n(oe_a), .mem_we_n(wen_a)
  );

  mem_bus_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(0)) dut_b (
    .clk(clk), .resetn(resetn), .req(req_b), .we(we_b), .addr(addr_b),
    .wr_data(wr_b), .rd_data(rd_b), .rdy(rdy_b), .busy(busy_b), .ovr(ovr_b),
    .mem_addr(maddr_b), .mem_dout(mdout_b), .mem_din(din_b),
    .mem_ce_n(ce_b), .mem_oe_n(oe_b), .mem_we_n(wen_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    vec++; if ({ce_a, oe_a, wen_a} !== 3'b111) begin miss++; $display("FAIL rst_strobes got %b want 111", {ce_a, oe_a, wen_a}); end
    vec++; if ({rdy_a, busy_a, ovr_a} !== 3'b000) begin miss++; $display("FAIL rst_flags got %b want 000", {rdy_a, busy_a, ovr_a}); end
    vec++; if (rd_a !== 8'h00) begin miss++; $display("FAIL rst_rd_data got %h want 00", rd_a); end
    vec++; if (maddr_a !== 16'h0000 || mdout_a !== 8'h00) begin miss++; $display("FAIL rst_mem_bus got %h/%h want 0000/00", maddr_a, mdout_a); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_read();
    din_a = 8'h34; addr_a = 16'hFFFC; we_a = 1'b0; req_a = 1'b1;
    tick(); req_a = 1'b0;                                   // n+1
    vec++; if ({ce_a, oe_a, wen_a} !== 3'b001) begin miss++; $display("FAIL rd_acc1_strobes got %b want 001", {ce_a, oe_a, wen_a}); end
    vec++; if (busy_a !== 1'b1 || rdy_a !== 1'b0) begin miss++; $display("FAIL rd_acc1_flags got busy=%b rdy=%b want 1/0", busy_a, rdy_a); end
    vec++; if (maddr_a !== 16'hFFFC) begin miss++; $display("FAIL rd_addr got %h want FFFC", maddr_a); end
    tick();                                                 // n+2
    vec++; if ({ce_a, oe_a, rdy_a} !== 3'b000) begin miss++; $display("FAIL rd_acc2 got ce/oe/rdy=%b want 000", {ce_a, oe_a, rdy_a}); end
    vec++; if (rd_a !== 8'h00) begin miss++; $display("FAIL rd_early got %h want 00", rd_a); end
    tick();                                                 // n+3
    vec++; if ({ce_a, oe_a, wen_a, rdy_a} !== 4'b0111) begin miss++; $display("FAIL rd_done got ce/oe/we/rdy=%b want 0111", {ce_a, oe_a, wen_a, rdy_a}); end
    vec++; if (rd_a !== 8'h34) begin miss++; $display("FAIL rd_data got %h want 34", rd_a); end
    tick();                                                 // n+4
    vec++; if ({busy_a, rdy_a, ce_a} !== 3'b001) begin miss++; $display("FAIL rd_idle got busy/rdy/ce=%b want 001", {busy_a, rdy_a, ce_a}); end
    vec++; if (rd_a !== 8'h34) begin miss++; $display("FAIL rd_hold got %h want 34", rd_a); end
  endtask

  task automatic test_write();
    din_a = 8'h55; addr_a = 16'h0200; wr_a = 8'hA9; we_a = 1'b1; req_a = 1'b1;
    tick(); req_a = 1'b0; we_a = 1'b0; addr_a = 16'hDEAD; wr_a = 8'h11;  // n+1
    vec++; if ({ce_a, oe_a, wen_a} !== 3'b010) begin miss++; $display("FAIL wr_acc1_strobes got %b want 010", {ce_a, oe_a, wen_a}); end
    vec++; if (maddr_a !== 16'h0200 || mdout_a !== 8'hA9) begin miss++; $display("FAIL wr_acc1_bus got %h/%h want 0200/A9", maddr_a, mdout_a); end
    tick();                                                 // n+2
    vec++; if (wen_a !== 1'b0 || rdy_a !== 1'b0) begin miss++; $display("FAIL wr_acc2 got we_n=%b rdy=%b want 0/0", wen_a, rdy_a); end
    tick();                                                 // n+3
    vec++; if ({ce_a, oe_a, wen_a, rdy_a} !== 4'b0111) begin miss++; $display("FAIL wr_done got ce/oe/we/rdy=%b want 0111", {ce_a, oe_a, wen_a, rdy_a}); end
    vec++; if (maddr_a !== 16'h0200 || mdout_a !== 8'hA9) begin miss++; $display("FAIL wr_done_bus got %h/%h want 0200/A9", maddr_a, mdout_a); end
    vec++; if (rd_a !== 8'h34) begin miss++; $display("FAIL wr_rd_data got %h want 34", rd_a); end
    tick();                                                 // n+4
    vec++; if (busy_a !== 1'b0 || ce_a !== 1'b1) begin miss++; $display("FAIL wr_idle got busy=%b ce_n=%b want 0/1", busy_a, ce_a); end
    vec++; if (maddr_a !== 16'h0200 || rd_a !== 8'h34) begin miss++; $display("FAIL wr_retain got %h/%h want 0200/34", maddr_a, rd_a); end
  endtask

  task automatic test_overrun();
    int pulses = 0;
    din_a = 8'h5A; addr_a = 16'h0300; we_a = 1'b0; req_a = 1'b1;
    tick();                                                 // n+1, ACCESS
    addr_a = 16'h1234; we_a = 1'b1; wr_a = 8'hEE;           // req still high
    tick(); req_a = 1'b0; we_a = 1'b0;                      // n+2
    vec++; if (ovr_a !== 1'b1) begin miss++; $display("FAIL ovr_set got %b want 1", ovr_a); end
    vec++; if (maddr_a !== 16'h0300 || oe_a !== 1'b0 || wen_a !== 1'b1) begin miss++; $display("FAIL ovr_addr got %h oe_n=%b we_n=%b want 0300/0/1", maddr_a, oe_a, wen_a); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rdy_a === 1'b1) pulses++;
    end
    vec++; if (pulses !== 1) begin miss++; $display("FAIL ovr_rdy_count got %0d want 1", pulses); end
    vec++; if (rd_a !== 8'h5A || maddr_a !== 16'h0300) begin miss++; $display("FAIL ovr_result got %h/%h want 5A/0300", rd_a, maddr_a); end
    vec++; if (ovr_a !== 1'b1 || busy_a !== 1'b0) begin miss++; $display("FAIL ovr_sticky got ovr=%b busy=%b want 1/0", ovr_a, busy_a); end
  endtask

  task automatic test_abort();
    int pulses = 0;
    din_a = 8'h77; addr_a = 16'h0400; we_a = 1'b0; req_a = 1'b1;
    tick(); req_a = 1'b0;                                   // ACCESS
    vec++; if (oe_a !== 1'b0) begin miss++; $display("FAIL abort_pre got oe_n=%b want 0", oe_a); end
    resetn = 1'b0;
    #1;
    vec++; if ({ce_a, oe_a, wen_a} !== 3'b111) begin miss++; $display("FAIL abort_strobes got %b want 111", {ce_a, oe_a, wen_a}); end
    vec++; if ({busy_a, rdy_a, ovr_a} !== 3'b000) begin miss++; $display("FAIL abort_flags got %b want 000", {busy_a, rdy_a, ovr_a}); end
    tick(); tick();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rdy_a === 1'b1) pulses++;
    end
    vec++; if (pulses !== 0) begin miss++; $display("FAIL abort_rdy got %0d pulses want 0", pulses); end
    vec++; if (busy_a !== 1'b0 || ce_a !== 1'b1 || rd_a !== 8'h00) begin miss++; $display("FAIL abort_idle got busy=%b ce_n=%b rd=%h want 0/1/00", busy_a, ce_a, rd_a); end
  endtask

  task automatic test_back_to_back();
    addr_b = 16'hFFFC; we_b = 1'b0; req_b = 1'b1;
    tick(); req_b = 1'b0;                                   // n+1
    vec++; if ({ce_b, oe_b, rdy_b} !== 3'b000) begin miss++; $display("FAIL b2b_acc1 got ce/oe/rdy=%b want 000", {ce_b, oe_b, rdy_b}); end
    tick();                                                 // n+2
    vec++; if (rdy_b !== 1'b1 || rd_b !== 8'h00) begin miss++; $display("FAIL b2b_rdy1 got rdy=%b rd=%h want 1/00", rdy_b, rd_b); end
    tick();                                                 // n+3
    vec++; if (rdy_b !== 1'b0 || busy_b !== 1'b0) begin miss++; $display("FAIL b2b_idle got rdy=%b busy=%b want 0/0", rdy_b, busy_b); end
    addr_b = 16'hFFFD; req_b = 1'b1;
    tick(); req_b = 1'b0;                                   // n+4
    vec++; if (oe_b !== 1'b0 || maddr_b !== 16'hFFFD || rdy_b !== 1'b0) begin miss++; $display("FAIL b2b_acc2 got oe_n=%b addr=%h rdy=%b want 0/FFFD/0", oe_b, maddr_b, rdy_b); end
    tick();                                                 // n+5
    vec++; if (rdy_b !== 1'b1 || rd_b !== 8'h80) begin miss++; $display("FAIL b2b_rdy2 got rdy=%b rd=%h want 1/80", rdy_b, rd_b); end
    tick();                                                 // n+6
    vec++; if (ovr_b !== 1'b0 || busy_b !== 1'b0 || rd_b !== 8'h80) begin miss++; $display("FAIL b2b_end got ovr=%b busy=%b rd=%h want 0/0/80", ovr_b, busy_b, rd_b); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_overrun();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
